// File: rtl/sqrt_operand_normalizer.sv
// Operand normalizer ahead of the non-restoring square-root core: normalizes denormals,
// fixes exponent parity, emits a 2.52 radicand plus biased result exponent, or bypasses specials.
module sqrt_operand_normalizer #(
  parameter int SIZE          = 64,
  parameter int EXPONENT_SIZE = 11,
  parameter int MANTISSA_SIZE = 52
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic                       isFloat,
  input  logic [SIZE-1:0]            handlerOut,
  input  logic                       isInputNormalized,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       isSpecial,
  output logic [SIZE-1:0]            specialResult,
  output logic [MANTISSA_SIZE+1:0]   radicand,
  output logic [EXPONENT_SIZE-1:0]   resultExponent,
  output logic                       outIsFloat
);

  localparam int SIG_W  = MANTISSA_SIZE + 1;
  localparam int EXP_W  = EXPONENT_SIZE + 2;
  localparam int F_MANT = 23;
  localparam int F_EXP  = 8;
  localparam int F_PAD  = MANTISSA_SIZE - F_MANT;

  localparam logic signed [EXP_W-1:0] BIAS_D = EXP_W'((1 << (EXPONENT_SIZE - 1)) - 1);
  localparam logic signed [EXP_W-1:0] BIAS_F = EXP_W'(127);
  localparam logic signed [EXP_W-1:0] ONE    = EXP_W'(1);

  typedef enum logic [1:0] {IDLE, NORM, PREP, DONE} state_t;

  state_t                     r_state;
  logic                       r_inReady;
  logic                       r_outValid;
  logic                       r_isSpecial;
  logic [SIZE-1:0]            r_specialResult;
  logic [MANTISSA_SIZE+1:0]   r_radicand;
  logic [EXPONENT_SIZE-1:0]   r_resultExponent;
  logic                       r_isFloat;
  logic [SIG_W-1:0]           r_sig;
  logic signed [EXP_W-1:0]    r_exp;

  logic [EXPONENT_SIZE-1:0]   w_e;
  logic                       w_eNonZero;
  logic [SIG_W-1:0]           w_sig;
  logic signed [EXP_W-1:0]    w_inBias;
  logic signed [EXP_W-1:0]    w_unbiased;
  logic signed [EXP_W-1:0]    w_prepBias;
  logic signed [EXP_W-1:0]    w_evenExp;
  logic signed [EXP_W-1:0]    w_resExp;

  // Operand field extraction for the capture in IDLE
  assign w_e        = isFloat ? {{(EXPONENT_SIZE-F_EXP){1'b0}}, handlerOut[F_MANT +: F_EXP]}
                              : handlerOut[MANTISSA_SIZE +: EXPONENT_SIZE];
  assign w_eNonZero = |w_e;
  assign w_sig      = isFloat ? {w_eNonZero, handlerOut[F_MANT-1:0], {F_PAD{1'b0}}}
                              : {w_eNonZero, handlerOut[MANTISSA_SIZE-1:0]};
  assign w_inBias   = isFloat ? BIAS_F : BIAS_D;
  assign w_unbiased = (w_eNonZero ? $signed({2'b00, w_e}) : ONE) - w_inBias;

  // Even exponent halves exactly; odd exponent borrows one into the radicand
  assign w_prepBias = r_isFloat ? BIAS_F : BIAS_D;
  assign w_evenExp  = r_exp[0] ? r_exp - ONE : r_exp;
  assign w_resExp   = (w_evenExp >>> 1) + w_prepBias;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state          <= IDLE;
      r_inReady        <= 1'b1;
      r_outValid       <= 1'b0;
      r_isSpecial      <= 1'b0;
      r_specialResult  <= '0;
      r_radicand       <= '0;
      r_resultExponent <= '0;
      r_isFloat        <= 1'b0;
      r_sig            <= '0;
      r_exp            <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inValid) begin
            r_inReady <= 1'b0;
            r_isFloat <= isFloat;
            r_sig     <= w_sig;
            r_exp     <= w_unbiased;
            if (!isInputNormalized || (w_sig == '0)) begin
              r_isSpecial     <= 1'b1;
              r_specialResult <= handlerOut;
              r_outValid      <= 1'b1;
              r_state         <= DONE;
            end else if (w_eNonZero) begin
              r_state <= PREP;
            end else begin
              r_state <= NORM;
            end
          end
        end
        NORM: begin
          // Leave on the shift that sets the hidden bit, so k shifts take exactly k cycles
          if (r_sig[SIG_W-1]) begin
            r_state <= PREP;
          end else begin
            r_sig <= r_sig << 1;
            r_exp <= r_exp - ONE;
            if (r_sig[SIG_W-2]) r_state <= PREP;
          end
        end
        PREP: begin
          r_radicand       <= r_exp[0] ? {r_sig, 1'b0} : {1'b0, r_sig};
          r_resultExponent <= w_resExp[EXPONENT_SIZE-1:0];
          r_isSpecial      <= 1'b0;
          r_specialResult  <= '0;
          r_outValid       <= 1'b1;
          r_state          <= DONE;
        end
        DONE: begin
          if (outReady) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_inReady <= 1'b1;
        end
      endcase
    end
  end

  assign inReady        = r_inReady;
  assign outValid       = r_outValid;
  assign isSpecial      = r_isSpecial;
  assign specialResult  = r_specialResult;
  assign radicand       = r_radicand;
  assign resultExponent = r_resultExponent;
  assign outIsFloat     = r_isFloat;

endmodule
